dtree_serial_eval: RTL and testbench
====================================

DTREE_SERIAL_EVAL -- requirements
Module: dtree_serial_eval

Interface
REQ-001 SHALL provide parameter NFEAT, default 20, number of input features.
REQ-002 SHALL provide parameter FW, default 8, feature and threshold width.
REQ-003 SHALL provide parameter AW, default 6, node address width (2^AW nodes).
REQ-004 SHALL provide parameter CW, default 2, class width.
REQ-005 SHALL provide parameter MAXDEPTH, default 16, traversal cycle limit.
REQ-006 SHALL provide ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  feature word valid.
- in_ready  output  1  feature word accepted.
- in_feat  input  FW  feature value, supplied in index order 0..NFEAT-1.
- cfg_we  input  1  node table write strobe.
- cfg_addr  input  AW  node table address.
- cfg_wdata  input  1+5+FW+2*AW  node word {leaf, fidx[4:0], thr[FW-1:0], left[AW-1:0], right[AW-1:0]}; for leaf words, class sits in the low CW bits.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed.
- out_class  output  CW  predicted class.
- out_err  output  1  traversal aborted at depth limit.
- busy  output  1  high in any state other than LOAD with zero features captured.

Function
REQ-007 SHALL implement FSM states LOAD, EVAL, DONE.
REQ-008 In LOAD, in_ready SHALL be 1; each cycle with in_valid&in_ready SHALL store in_feat at index fcnt and increment fcnt.
REQ-009 On the handshake with fcnt==NFEAT-1, the block SHALL clear fcnt, set node pointer to 0 and depth to 0, and enter EVAL next cycle.
REQ-010 In EVAL and DONE, in_ready SHALL be 0.
REQ-011 In EVAL, the block SHALL visit exactly one node per cycle, reading node_table[ptr] combinationally.
REQ-012 Non-leaf visit SHALL compare feat[fidx] <= thr (unsigned), load ptr with left if true and right if false, and increment depth.
REQ-013 fidx >= NFEAT SHALL compare the value 0.
REQ-014 Leaf visit SHALL register out_class = class bits and out_err = 0, and enter DONE.
REQ-015 A non-leaf visit with depth == MAXDEPTH-1 SHALL register out_class = 0 and out_err = 1, and enter DONE.
REQ-016 Latency: last feature handshake at edge T gives root visit in cycle T+1, a leaf at depth d in cycle T+1+d, and out_valid=1 from cycle T+2+d.
REQ-017 In DONE, out_valid SHALL be 1 with out_class and out_err stable until out_valid&out_ready, after which the block SHALL return to LOAD next cycle.
REQ-018 out_valid SHALL be 0 in LOAD and EVAL.
REQ-019 cfg_we SHALL write node_table[cfg_addr] only when busy==0; otherwise the write SHALL be silently dropped.
REQ-020 When cfg_we and in_valid are both asserted with busy==0, both SHALL take effect in the same cycle.
REQ-021 Feature words SHALL NOT be accepted while in DONE, regardless of in_valid.

Reset
REQ-022 rst SHALL force, asynchronously:
- state = LOAD, fcnt = 0, ptr = 0, depth = 0;
- out_valid = 0, out_class = 0, out_err = 0;
- in_ready = 1 once rst deasserts, busy = 0.
REQ-023 Reset SHALL NOT clear the node table or feature registers.
REQ-024 Reset asserted mid-EVAL or mid-DONE SHALL abandon the inference with no out_valid pulse.

Verification
REQ-025 Single leaf at node 0, class 2; stream 20 features -> out_valid 2 cycles after last handshake, out_class=2, out_err=0.
REQ-026 Root {fidx=7, thr=0xA0, left=1, right=2}, node1 leaf class 1, node2 leaf class 3:
- feat7=0xA0 -> class 1;
- feat7=0xA1 -> class 3;
- out_valid 3 cycles after last handshake in both cases.
REQ-027 Node 0 non-leaf with left=right=0 -> out_err=1, out_class=0 exactly MAXDEPTH+1 cycles after last handshake.
REQ-028 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_class stable, in_ready=0, in_valid ignored; out_ready=1 -> LOAD next cycle.
REQ-029 cfg_we with busy=1 changes no table entry (verified by re-run); rst asserted in EVAL -> out_valid stays 0 and in_ready=1 after release.

Source files
------------

// File: rtl/dtree_serial_eval.sv
// Serial decision-tree evaluator: streams NFEAT features in, walks the node table
// one node per cycle from node 0, and holds the predicted class until consumed.
module dtree_serial_eval #(
  parameter int NFEAT    = 20,
  parameter int FW       = 8,
  parameter int AW       = 6,
  parameter int CW       = 2,
  parameter int MAXDEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FW-1:0]           in_feat,
  input  logic                    cfg_we,
  input  logic [AW-1:0]           cfg_addr,
  input  logic [1+5+FW+2*AW-1:0]  cfg_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CW-1:0]           out_class,
  output logic                    out_err,
  output logic                    busy
);

  localparam int WW  = 1 + 5 + FW + 2 * AW;
  localparam int FCW = (NFEAT > 1) ? $clog2(NFEAT) : 1;
  localparam int DW  = $clog2(MAXDEPTH + 1);

  typedef enum logic [1:0] {LOAD, EVAL, DONE} state_t;

  state_t          state_q, state_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [CW-1:0]   class_q, class_d;
  logic            err_q, err_d;
  logic            feat_we;

  logic [FW-1:0]   feat_q [NFEAT];
  logic [WW-1:0]   node_table [2**AW];

  logic [WW-1:0]   node_w;
  logic            n_leaf;
  logic [4:0]      n_fidx;
  logic [FW-1:0]   n_thr;
  logic [AW-1:0]   n_left, n_right;
  logic [FW-1:0]   sel_feat;

  assign node_w  = node_table[ptr_q];
  assign n_leaf  = node_w[WW-1];
  assign n_fidx  = node_w[WW-2 -: 5];
  assign n_thr   = node_w[2*AW +: FW];
  assign n_left  = node_w[AW +: AW];
  assign n_right = node_w[0 +: AW];

  // Out-of-range feature indices fall through to a compare value of zero.
  always_comb begin
    sel_feat = '0;
    for (int i = 0; i < NFEAT; i++) begin
      if (n_fidx == 5'(i)) sel_feat = feat_q[i];
    end
  end

  assign busy      = !((state_q == LOAD) && (fcnt_q == '0));
  assign out_class = class_q;
  assign out_err   = err_q;

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    ptr_d     = ptr_q;
    depth_d   = depth_q;
    class_d   = class_q;
    err_d     = err_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    feat_we   = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          feat_we = 1'b1;
          if (fcnt_q == FCW'(NFEAT - 1)) begin
            fcnt_d  = '0;
            ptr_d   = '0;
            depth_d = '0;
            state_d = EVAL;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      EVAL: begin
        if (n_leaf) begin
          class_d = node_w[0 +: CW];
          err_d   = 1'b0;
          state_d = DONE;
        end else if (depth_q == DW'(MAXDEPTH - 1)) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          ptr_d   = (sel_feat <= n_thr) ? n_left : n_right;
          depth_d = depth_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      fcnt_q  <= '0;
      ptr_q   <= '0;
      depth_q <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately outside reset so a reset never loses the loaded tree.
  always_ff @(posedge clk) begin
    if (feat_we) feat_q[fcnt_q] <= in_feat;
    if (cfg_we && !busy) node_table[cfg_addr] <= cfg_wdata;
  end

endmodule

// File: tb/tb_dtree_serial_eval.sv
// Randomized self-checking bench for dtree_serial_eval against a tree-walk model.
module tb_dtree_serial_eval;

  localparam int NFEAT    = 20;
  localparam int FW       = 8;
  localparam int AW       = 6;
  localparam int CW       = 2;
  localparam int MAXDEPTH = 16;
  localparam int WW       = 1 + 5 + FW + 2 * AW;
  localparam int NNODE    = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [FW-1:0] in_feat = '0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [WW-1:0] cfg_wdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_class;
  logic          out_err;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [FW-1:0] feat_m [NFEAT];
  logic [WW-1:0] tbl_m  [NNODE];

  dtree_serial_eval #(
    .NFEAT(NFEAT), .FW(FW), .AW(AW), .CW(CW), .MAXDEPTH(MAXDEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] mk_node(int fi, int thr, int l, int r);
    return {1'b0, 5'(fi), FW'(thr), AW'(l), AW'(r)};
  endfunction

  function automatic logic [WW-1:0] mk_leaf(int c);
    return {1'b1, 5'd0, FW'(0), AW'(0), AW'(c)};
  endfunction

  // Walk the tree from node 0; edges = clock edges after the last feature
  // handshake until out_valid is visible (leaf at depth d -> d+1).
  function automatic void model_eval(output int cls, output int err, output int edges);
    int p;
    p = 0;
    for (int d = 0; d < MAXDEPTH; d++) begin
      logic [WW-1:0] w;
      int fi, v, thr;
      w = tbl_m[p];
      if (w[WW-1]) begin
        cls = int'(w[CW-1:0]);
        err = 0;
        edges = d + 1;
        return;
      end
      fi  = int'(w[WW-2 -: 5]);
      v   = (fi < NFEAT) ? int'(feat_m[fi]) : 0;
      thr = int'(w[2*AW +: FW]);
      p   = (v <= thr) ? int'(w[AW +: AW]) : int'(w[AW-1:0]);
    end
    cls = 0;
    err = 1;
    edges = MAXDEPTH;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_node(input int a, input logic [WW-1:0] w);
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_wdata = w;
    step();
    cfg_we = 1'b0;
    tbl_m[a] = w;
  endtask

  task automatic rand_feats();
    for (int i = 0; i < NFEAT; i++) feat_m[i] = FW'($urandom);
  endtask

  // Streams feat_m, optionally strobing one cfg write alongside feature cfg_at,
  // then waits (bounded) for out_valid and reports what the DUT produced.
  task automatic do_infer(input int cfg_at, input int caddr, input logic [WW-1:0] cdata,
                          output int cls, output int err, output int edges, output bit tmo);
    for (int i = 0; i < NFEAT; i++) begin
      in_valid = 1'b1;
      in_feat  = feat_m[i];
      if (i == cfg_at) begin
        cfg_we = 1'b1;
        cfg_addr = AW'(caddr);
        cfg_wdata = cdata;
      end
      step();
      cfg_we = 1'b0;
    end
    in_valid = 1'b0;
    edges = 0;
    tmo = 1'b0;
    while (!out_valid) begin
      if (edges >= 60) begin
        tmo = 1'b1;
        break;
      end
      step();
      edges++;
    end
    cls = int'(out_class);
    err = int'(out_err);
    $display("[TB] infer class=%0d err=%0d edges=%0d", cls, err, edges);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_class !== '0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_during: out_valid=%b busy=%b class=%0d err=%b required 0 0 0 0",
               out_valid, busy, out_class, out_err);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: in_ready=%b busy=%b out_valid=%b required 1 0 0",
               in_ready, busy, out_valid);
    end
    for (int a = 0; a < NNODE; a++) write_node(a, mk_leaf(0));
  endtask

  task automatic check_result(input string name, input int cls, input int err,
                              input int edges, input bit tmo);
    int ec, ee, ed;
    model_eval(ec, ee, ed);
    n_tests++;
    if (tmo || cls != ec || err != ee || edges != ed) begin
      n_fail++;
      $display("FAIL %s: class=%0d err=%0d edges=%0d timeout=%0d required class=%0d err=%0d edges=%0d",
               name, cls, err, edges, tmo, ec, ee, ed);
    end
  endtask

  task automatic test_single_leaf();
    int c, e, n;
    bit t;
    write_node(0, mk_leaf(2));
    rand_feats();
    do_infer(-1, 0, '0, c, e, n, t);
    n_tests++;
    if (t || c != 2 || e != 0 || n != 1) begin
      n_fail++;
      $display("FAIL single_leaf: class=%0d err=%0d edges=%0d required 2 0 1", c, e, n);
    end
    consume();
  endtask

  task automatic test_threshold();
    int c, e, n;
    bit t;
    write_node(0, mk_node(7, 8'hA0, 1, 2));
    write_node(1, mk_leaf(1));
    write_node(2, mk_leaf(3));
    for (int k = 0; k < 2; k++) begin
      rand_feats();
      feat_m[7] = (k == 0) ? 8'hA0 : 8'hA1;
      do_infer(-1, 0, '0, c, e, n, t);
      n_tests++;
      if (t || c != ((k == 0) ? 1 : 3) || e != 0 || n != 2) begin
        n_fail++;
        $display("FAIL threshold_%0d: class=%0d err=%0d edges=%0d required %0d 0 2",
                 k, c, e, n, (k == 0) ? 1 : 3);
      end
      consume();
    end
  endtask

  task automatic test_depth_limit();
    int c, e, n;
    bit t;
    write_node(0, mk_node(3, 8'h10, 0, 0));
    rand_feats();
    do_infer(-1, 0, '0, c, e, n, t);
    n_tests++;
    if (t || c != 0 || e != 1 || n != MAXDEPTH) begin
      n_fail++;
      $display("FAIL depth_limit: class=%0d err=%0d edges=%0d required 0 1 %0d", c, e, n, MAXDEPTH);
    end
    consume();
  endtask

  task automatic test_random_trees();
    int c, e, n;
    bit t;
    for (int it = 0; it < 24; it++) begin
      for (int a = 0; a < NNODE; a++) begin
        if ($urandom_range(0, 2) == 0)
          write_node(a, mk_leaf(int'($urandom_range(0, 3))));
        else
          write_node(a, mk_node(int'($urandom_range(0, 31)), int'($urandom_range(0, 255)),
                                int'($urandom_range(0, NNODE - 1)), int'($urandom_range(0, NNODE - 1))));
      end
      rand_feats();
      do_infer(-1, 0, '0, c, e, n, t);
      check_result("random_tree", c, e, n, t);
      repeat ($urandom_range(0, 3)) step();
      consume();
    end
  endtask

  task automatic test_hold_done();
    int c, e, n;
    bit t;
    write_node(0, mk_node(7, 8'hA0, 1, 2));
    write_node(1, mk_leaf(1));
    write_node(2, mk_leaf(3));
    rand_feats();
    do_infer(-1, 0, '0, c, e, n, t);
    check_result("hold_first", c, e, n, t);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_feat = FW'($urandom);
      step();
      n_tests++;
      if (out_valid !== 1'b1 || int'(out_class) != c || int'(out_err) != e || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_done_%0d: out_valid=%b class=%0d err=%b in_ready=%b required 1 %0d %0d 0",
                 k, out_valid, out_class, out_err, in_ready, c, e);
      end
    end
    in_valid = 1'b0;
    consume();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_cfg_busy();
    int c, e, n;
    bit t;
    write_node(0, mk_node(7, 8'hA0, 1, 2));
    write_node(1, mk_leaf(1));
    write_node(2, mk_leaf(3));
    rand_feats();
    feat_m[7] = 8'hA0;
    do_infer(5, 1, mk_leaf(2), c, e, n, t);
    check_result("cfg_busy_load", c, e, n, t);
    cfg_we = 1'b1;
    cfg_addr = AW'(1);
    cfg_wdata = mk_leaf(0);
    step();
    cfg_we = 1'b0;
    consume();
    do_infer(-1, 0, '0, c, e, n, t);
    n_tests++;
    if (t || c != 1 || e != 0) begin
      n_fail++;
      $display("FAIL cfg_busy_rerun: class=%0d err=%0d required 1 0", c, e);
    end
    consume();
  endtask

  task automatic test_cfg_concurrent();
    int c, e, n;
    bit t;
    write_node(0, mk_node(0, 8'h80, 1, 2));
    write_node(1, mk_leaf(1));
    write_node(2, mk_leaf(3));
    rand_feats();
    feat_m[0] = FW'(8'h80 + $urandom_range(1, 127));
    tbl_m[2] = mk_leaf(0);
    do_infer(0, 2, mk_leaf(0), c, e, n, t);
    check_result("cfg_concurrent", c, e, n, t);
    consume();
  endtask

  task automatic test_reset_eval();
    int c, e, n, seen;
    bit t;
    write_node(0, mk_node(3, 8'h10, 0, 0));
    rand_feats();
    for (int i = 0; i < NFEAT; i++) begin
      in_valid = 1'b1;
      in_feat = feat_m[i];
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: out_valid=%b busy=%b required 0 0", out_valid, busy);
    end
    step();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < MAXDEPTH + 4; k++) begin
      step();
      if (out_valid === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_eval: valid_cycles=%0d in_ready=%b busy=%b required 0 1 0",
               seen, in_ready, busy);
    end
    rand_feats();
    do_infer(-1, 0, '0, c, e, n, t);
    check_result("table_kept", c, e, n, t);
    consume();
  endtask

  initial begin
    repeat (2) step();
    test_reset();
    test_single_leaf();
    test_threshold();
    test_depth_limit();
    test_random_trees();
    test_hold_done();
    test_cfg_busy();
    test_cfg_concurrent();
    test_reset_eval();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
